// File: rtl/muldiv_hilo.sv
// MIPS32 multiply/divide unit owning HI/LO: iterative radix-2 MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Optional single-cycle multiplier when MULDIV_FAST_MUL_EN is defined (division stays iterative).
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO accepted
  // RUN   | one radix-2 step per edge until the last step writes hi/lo
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam int   W2      = 2 * WIDTH;

  logic             state, state_n;
  logic [4:0]       cnt;
  logic             is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0] a_raw, mcand;
  logic [W2-1:0]    prod;

  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             last_step;
  logic [WIDTH:0]   sum, rem_sh, diff;
  logic [W2-1:0]    step_next, mul_res;
  logic [WIDTH-1:0] quo, rem;

  assign op_signed = ~op[0];
  assign abs_a = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op_signed && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  assign last_step = (cnt == 5'd31) || !is_div;
`else
  assign last_step = (cnt == 5'd31);
`endif

  // Datapath: prod holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sum       = {1'b0, prod[W2-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    rem_sh    = {prod[W2-1:WIDTH], prod[WIDTH-1]};
    diff      = rem_sh - {1'b0, mcand};
    step_next = {sum, prod[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) step_next = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      else              step_next = {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      step_next = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
    end
`endif
    mul_res = neg_q ? -step_next : step_next;
    quo     = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem     = neg_r ? -step_next[W2-1:WIDTH] : step_next[W2-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start)     state_n = ST_RUN;
      ST_RUN:  if (last_step) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
      mcand  <= '0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          cnt    <= '0;
          is_div <= op[1];
          neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r  <= op_signed && a[WIDTH-1];
          div0   <= (b == '0);
          a_raw  <= a;
          if (op[1]) begin
            mcand <= abs_b;
            prod  <= {{WIDTH{1'b0}}, abs_a};
          end else begin
            mcand <= abs_a;
            prod  <= {{WIDTH{1'b0}}, abs_b};
          end
        end else begin
          if (write_hi) hi <= wdata;
          if (write_lo) lo <= wdata;
        end
      end else begin
        cnt  <= cnt + 5'd1;
        prod <= step_next;
        if (last_step) begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= mul_res[W2-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end else if (div0) begin
            // Divide by zero is architecturally unpredictable; return dividend / all-ones
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed scoreboard bench for muldiv_hilo: results queued at start, checked when done pulses.
module tb_muldiv_hilo;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, start, write_hi, write_lo;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, wdata;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  muldiv_hilo #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    e.lat = 32;
    case (o)
      2'b00: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        e.hi = p[63:32]; e.lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
        e.lat = 1;
`endif
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32]; e.lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
        e.lat = 1;
`endif
      end
      2'b10: begin
        if (y == 0) begin e.hi = x; e.lo = 32'hFFFFFFFF; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin e.hi = 0; e.lo = 32'h80000000; end
        else begin e.lo = sx / sy; e.hi = sx % sy; end
      end
      default: begin
        if (y == 0) begin e.hi = x; e.lo = 32'hFFFFFFFF; end
        else begin e.lo = x / y; e.hi = x % y; end
      end
    endcase
    return e;
  endfunction

  // Called at posedge+1; drives start this cycle, waits for done and checks the queued result.
  // perturb=1 pokes start/write_lo/operands mid-operation, which must have no effect.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit perturb);
    exp_t e;
    int   nbusy;
    int   cyc;
    exp_q.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    nbusy = 0;
    cyc   = 0;
    while (!done && cyc < 200) begin
      if (busy) nbusy++;
      if (perturb && cyc == 4) begin
        start = 1'b1; write_lo = 1'b1; wdata = 32'hDEADBEEF;
        a = 32'h55555555; b = 32'h3; op = 2'b00;
      end else if (perturb && cyc == 5) begin
        start = 1'b0; write_lo = 1'b0;
      end
      step();
      cyc++;
    end
    e = exp_q.pop_front();
    if (!done) begin
      check({tag, "_timeout"}, 64'(done), 64'd1);
    end else begin
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'(e.lat));
      check({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    step(); step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    step();

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    step();
    check("done_one_cycle", 64'(done), 64'd0);
    check("hilo_hold", {hi, lo}, 64'hFFFFFFFE_00000001);

    run_op("mult_neg", 2'b00, -32'sd3, 32'd7, 0);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
    check("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 0);
    check("divu_by0_const", {hi, lo}, {32'd5, 32'hFFFFFFFF});
    run_op("div_by0", 2'b10, 32'hFFFFFFF0, 32'd0, 0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h80000000});

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 2) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
      run_op($sformatf("rand%0d", i), 2'(i % 4), ra, rb, 0);
    end

    step();
    write_hi = 1'b1; wdata = 32'h12345678;
    step();
    write_hi = 1'b0;
    check("mthi", 64'(hi), 64'h12345678);
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hCAFEF00D;
    step();
    write_hi = 1'b0; write_lo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, 64'hCAFEF00D_CAFEF00D);

    // start wins over a same-cycle MTHI
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; write_hi = 1'b1; wdata = 32'h0BADF00D;
    exp_q.push_back(model(2'b01, 32'd3, 32'd4));
    step();
    start = 1'b0; write_hi = 1'b0;
    check("start_drops_write", {hi, lo}, 64'hCAFEF00D_CAFEF00D);
    begin
      int cyc = 0;
      exp_t e;
      while (!done && cyc < 200) begin step(); cyc++; end
      e = exp_q.pop_front();
      check("start_write_result", {hi, lo}, {e.hi, e.lo});
    end

    run_op("divu_9_4_perturb", 2'b11, 32'd9, 32'd4, 1);
    check("divu_9_4_const", {hi, lo}, {32'd1, 32'd2});

    // back-to-back: second start issued in the done cycle
    run_op("b2b_first", 2'b11, 32'd50, 32'd6, 0);
    run_op("b2b_second", 2'b01, 32'd11, 32'd13, 0);

    op = 2'b01; a = 32'hFFFF0000; b = 32'h0000FFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("pre_abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) check("abort_spurious_done", 64'(done), 64'd0);
      step();
    end
    check("abort_hilo_later", {hi, lo}, 64'd0);

    run_op("multu_6_7", 2'b01, 32'd6, 32'd7, 0);
    check("multu_6_7_const", {hi, lo}, {32'd0, 32'd42});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
